// File: rtl/i2c_arbiter_if.sv
// Requester, master-side and grant/status signals of the two-requester I2C bus arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface i2c_arbiter_if;
  logic       req_disp;
  logic [6:0] disp_addr;
  logic [7:0] disp_data;
  logic       req_conv;
  logic [6:0] conv_addr;
  logic [7:0] conv_data;
  logic       master_done;
  logic       master_ack_err;
  logic       master_start;
  logic [6:0] master_addr;
  logic [7:0] master_data;
  logic       gnt_disp;
  logic       gnt_conv;
  logic       done_disp;
  logic       done_conv;
  logic       err_disp;
  logic       err_conv;

  modport slave (
    input  req_disp, disp_addr, disp_data,
    input  req_conv, conv_addr, conv_data,
    input  master_done, master_ack_err,
    output master_start, master_addr, master_data,
    output gnt_disp, gnt_conv, done_disp, done_conv, err_disp, err_conv
  );

  modport master (
    output req_disp, disp_addr, disp_data,
    output req_conv, conv_addr, conv_data,
    output master_done, master_ack_err,
    input  master_start, master_addr, master_data,
    input  gnt_disp, gnt_conv, done_disp, done_conv, err_disp, err_conv
  );
endinterface

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one I2C master between a display and a converter requester.
// Define ARB_TIMEOUT_EN to add a WAIT-state watchdog of TIMEOUT_CYCLES clocks.
module i2c_arbiter #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic          clk,
  input  logic          btn_reset,
  i2c_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, START, WAIT, RELEASE} state_t;

  state_t state;
  logic   last_conv;
  logic   err_latched;
  logic   done_disp_q;
  logic   done_conv_q;
  logic   pick_disp;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] wd_cnt;
`endif

  // Display wins when alone, or on a tie when the converter held the bus last.
  assign pick_disp = bus.req_disp && (!bus.req_conv || last_conv);

  assign bus.done_disp = done_disp_q;
  assign bus.done_conv = done_conv_q;
  assign bus.err_disp  = done_disp_q & err_latched;
  assign bus.err_conv  = done_conv_q & err_latched;

  always_ff @(posedge clk or negedge btn_reset) begin
    if (!btn_reset) begin
      state            <= IDLE;
      last_conv        <= 1'b1;
      err_latched      <= 1'b0;
      done_disp_q      <= 1'b0;
      done_conv_q      <= 1'b0;
      bus.master_start <= 1'b0;
      bus.master_addr  <= '0;
      bus.master_data  <= '0;
      bus.gnt_disp     <= 1'b0;
      bus.gnt_conv     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      wd_cnt           <= '0;
`endif
    end else begin
      bus.master_start <= 1'b0;
      done_disp_q      <= 1'b0;
      done_conv_q      <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_disp || bus.req_conv) begin
            state            <= START;
            bus.master_start <= 1'b1;
            bus.gnt_disp     <= pick_disp;
            bus.gnt_conv     <= !pick_disp;
            last_conv        <= !pick_disp;
            bus.master_addr  <= pick_disp ? bus.disp_addr : bus.conv_addr;
            bus.master_data  <= pick_disp ? bus.disp_data : bus.conv_data;
          end
        end
        START: begin
          state <= WAIT;
`ifdef ARB_TIMEOUT_EN
          wd_cnt <= '0;
`endif
        end
        // A real completion beats a watchdog expiry landing in the same cycle.
        WAIT: begin
          if (bus.master_done) begin
            state        <= RELEASE;
            err_latched  <= bus.master_ack_err;
            done_disp_q  <= bus.gnt_disp;
            done_conv_q  <= bus.gnt_conv;
            bus.gnt_disp <= 1'b0;
            bus.gnt_conv <= 1'b0;
          end
`ifdef ARB_TIMEOUT_EN
          else if (wd_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            state        <= RELEASE;
            err_latched  <= 1'b1;
            done_disp_q  <= bus.gnt_disp;
            done_conv_q  <= bus.gnt_conv;
            bus.gnt_disp <= 1'b0;
            bus.gnt_conv <= 1'b0;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Randomized scoreboard bench for i2c_arbiter: stimulus queues predicted grants, a monitor checks them.
// Timeout expectations follow whether ARB_TIMEOUT_EN is defined for the build.
module tb_i2c_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam bit TIMEOUT_BUILD = 1'b1;
`else
  localparam bit TIMEOUT_BUILD = 1'b0;
`endif

  typedef struct {
    bit         win_conv;
    logic [6:0] addr;
    logic [7:0] data;
    bit         err;
    int         start_cyc;
    int         done_off;
  } exp_t;

  typedef struct {
    int delay;
    bit nack;
  } resp_t;

  logic clk = 1'b0;
  logic btn_reset = 1'b0;
  i2c_arbiter_if bus();

  i2c_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk       (clk),
    .btn_reset (btn_reset),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  exp_t  exp_q[$];
  resp_t resp_q[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  bit    last_conv_model = 1'b1;
  bit    allow_spurious = 1'b0;
  bit    active = 1'b0;
  exp_t  cur;
  int    act_start = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops a prediction on every master_start and follows it to its done pulse.
  always @(negedge clk) begin
    if (!btn_reset) begin
      active = 1'b0;
    end else begin
      checkOutput("gnt_onehot", 32'(bus.gnt_disp & bus.gnt_conv), 32'd0);
      if (bus.master_start) begin
        if (exp_q.size() == 0) begin
          checkOutput("start_unexpected", 32'(bus.master_start), 32'd0);
        end else begin
          cur = exp_q.pop_front();
          active = 1'b1;
          act_start = cyc;
          checkOutput("start_latency", 32'(cyc), 32'(cur.start_cyc));
          checkOutput("start_gnt", 32'({bus.gnt_disp, bus.gnt_conv}),
                      cur.win_conv ? 32'd1 : 32'd2);
          checkOutput("start_addr", 32'(bus.master_addr), 32'(cur.addr));
          checkOutput("start_data", 32'(bus.master_data), 32'(cur.data));
        end
      end else if (bus.done_disp || bus.done_conv) begin
        if (!active) begin
          checkOutput("done_unexpected", 32'({bus.done_disp, bus.done_conv}), 32'd0);
        end else begin
          if (cur.done_off < 0)
            checkOutput("done_not_expected", 32'({bus.done_disp, bus.done_conv}), 32'd0);
          else
            checkOutput("done_cycle", 32'(cyc), 32'(act_start + cur.done_off));
          checkOutput("done_who", 32'({bus.done_disp, bus.done_conv}),
                      cur.win_conv ? 32'd1 : 32'd2);
          checkOutput("err_who", 32'({bus.err_disp, bus.err_conv}),
                      cur.err ? (cur.win_conv ? 32'd1 : 32'd2) : 32'd0);
          checkOutput("release_gnt", 32'({bus.gnt_disp, bus.gnt_conv}), 32'd0);
          checkOutput("hold_addr", 32'(bus.master_addr), 32'(cur.addr));
          checkOutput("hold_data", 32'(bus.master_data), 32'(cur.data));
          active = 1'b0;
        end
      end else begin
        checkOutput("err_without_done", 32'({bus.err_disp, bus.err_conv}), 32'd0);
        if (active)
          checkOutput("gnt_held", 32'({bus.gnt_disp, bus.gnt_conv}),
                      cur.win_conv ? 32'd1 : 32'd2);
      end
    end
  end

  // Master model: answers each start after the queued delay; idles with random noise on done/ack.
  initial begin
    resp_t r;
    bus.master_done = 1'b0;
    bus.master_ack_err = 1'b0;
    forever begin
      @(negedge clk);
      if (btn_reset && bus.master_start && resp_q.size() > 0) begin
        r = resp_q.pop_front();
        bus.master_done = 1'b0;
        if (r.delay > 0) begin
          repeat (r.delay) @(negedge clk);
          bus.master_done = 1'b1;
          bus.master_ack_err = r.nack;
          @(negedge clk);
          bus.master_done = 1'b0;
        end
      end else begin
        bus.master_ack_err = 1'($urandom);
        bus.master_done = allow_spurious && ($urandom_range(0, 3) == 0);
      end
    end
  end

  task automatic scramble();
    if ($urandom_range(0, 2) == 0) begin
      bus.disp_addr = 7'($urandom);
      bus.disp_data = 8'($urandom);
      bus.conv_addr = 7'($urandom);
      bus.conv_data = 8'($urandom);
      bus.req_disp  = 1'($urandom);
      bus.req_conv  = 1'($urandom);
    end
  endtask

  // pattern: 1 = display only, 2 = converter only, 3 = both
  task automatic applyStimulus(input int pattern, input logic [6:0] da, input logic [7:0] dd,
                               input logic [6:0] ca, input logic [7:0] cd,
                               input int delay, input bit nack, input bit no_done);
    exp_t  e;
    resp_t r;
    bit    wc;
    int    n;
    wc = (pattern == 2) || (pattern == 3 && !last_conv_model);
    last_conv_model = wc;
    e.win_conv = wc;
    e.addr = wc ? ca : da;
    e.data = wc ? cd : dd;
    if (no_done) begin
      e.err = TIMEOUT_BUILD;
      e.done_off = TIMEOUT_BUILD ? 17 : -1;
      r.delay = 0;
    end else begin
      e.err = nack;
      e.done_off = delay + 1;
      r.delay = delay;
    end
    r.nack = nack;
    @(negedge clk);
    bus.req_disp = (pattern != 2);
    bus.req_conv = (pattern != 1);
    bus.disp_addr = da;
    bus.disp_data = dd;
    bus.conv_addr = ca;
    bus.conv_data = cd;
    allow_spurious = 1'b0;
    e.start_cyc = cyc + 1;
    exp_q.push_back(e);
    resp_q.push_back(r);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.master_start && n < 4);
    if (!bus.master_start) checkOutput("start_seen", 32'(bus.master_start), 32'd1);
    if (no_done && !TIMEOUT_BUILD) begin
      repeat (60) begin
        @(negedge clk);
        scramble();
      end
      checkOutput("gnt_stuck", 32'(bus.gnt_disp), 32'(!wc));
    end else begin
      n = 0;
      forever begin
        @(negedge clk);
        n++;
        if (bus.done_disp || bus.done_conv) break;
        if (n >= 100) begin
          checkOutput("done_seen", 32'(bus.done_disp | bus.done_conv), 32'd1);
          break;
        end
        scramble();
      end
    end
    bus.req_disp = 1'b0;
    bus.req_conv = 1'b0;
    allow_spurious = 1'b1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;
    resp_t r;
    int n;
    bus.req_disp = 1'b0;
    bus.req_conv = 1'b0;
    bus.disp_addr = '0;
    bus.disp_data = '0;
    bus.conv_addr = '0;
    bus.conv_data = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", 32'({bus.master_start, bus.gnt_disp, bus.gnt_conv, bus.done_disp,
                bus.done_conv, bus.err_disp, bus.err_conv, bus.master_addr, bus.master_data}), 32'd0);
    btn_reset = 1'b1;

    applyStimulus(1, 7'h3C, 8'hA5, 7'h11, 8'h22, 10, 1'b0, 1'b0);
    repeat (3) applyStimulus(3, 7'($urandom), 8'($urandom), 7'($urandom), 8'($urandom),
                             $urandom_range(1, 12), 1'b0, 1'b0);
    applyStimulus(2, 7'h10, 8'h20, 7'h48, 8'h5A, 4, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      applyStimulus($urandom_range(1, 3), 7'($urandom), 8'($urandom), 7'($urandom),
                    8'($urandom), $urandom_range(1, 12), 1'($urandom), 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Reset in the middle of WAIT aborts the transaction silently.
    @(negedge clk);
    allow_spurious = 1'b0;
    bus.req_disp = 1'b1;
    bus.disp_addr = 7'h2A;
    bus.disp_data = 8'h6B;
    e.win_conv = 1'b0;
    e.addr = 7'h2A;
    e.data = 8'h6B;
    e.err = 1'b0;
    e.done_off = -1;
    e.start_cyc = cyc + 1;
    r.delay = 30;
    r.nack = 1'b1;
    exp_q.push_back(e);
    resp_q.push_back(r);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.master_start && n < 4);
    repeat (3) @(negedge clk);
    btn_reset = 1'b0;
    bus.req_disp = 1'b0;
    #1;
    checkOutput("reset_mid_wait", 32'({bus.master_start, bus.gnt_disp, bus.gnt_conv, bus.done_disp,
                bus.done_conv, bus.err_disp, bus.err_conv, bus.master_addr, bus.master_data}), 32'd0);
    repeat (3) @(negedge clk);
    btn_reset = 1'b1;
    last_conv_model = 1'b1;
    repeat (40) @(negedge clk);
    applyStimulus(3, 7'h01, 8'h02, 7'h03, 8'h04, 5, 1'b0, 1'b0);

    // Master never answers: watchdog release, or a grant that never drops.
    repeat (2) @(negedge clk);
    applyStimulus(1, 7'h55, 8'hC3, 7'h66, 8'h99, 0, 1'b0, 1'b1);
    @(negedge clk);
    btn_reset = 1'b0;
    repeat (2) @(negedge clk);
    btn_reset = 1'b1;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
